// File: rtl/timer_pkg.sv
// Shared constants for the BCD down-timer and a helper that pulls one digit field
// out of a packed per-digit vector.
package timer_pkg;

  localparam int unsigned TIMER_DIG_W = 4;
  localparam int unsigned TIMER_NDIG  = 4;
  // mm:ss layout, digit 0 in the LSBs: seconds units, seconds tens, minutes units, minutes tens
  localparam logic [TIMER_NDIG*TIMER_DIG_W-1:0] TIMER_MODS_MMSS = {4'd10, 4'd10, 4'd6, 4'd10};

  function automatic int unsigned get_digit(input logic [63:0] vec, input int unsigned idx,
                                            input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 32'((vec >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MOD down-counting digit with synchronous clear, clamped load and borrow input.
module mod_n_digit #(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  input  logic         bin_i,
  output logic [W-1:0] q_o,
  output logic         is_zero_o
);

  localparam logic [W-1:0] Max = W'(MOD - 1);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = (d_i > Max) ? Max : d_i;
    end else if (bin_i) begin
      q_d = (q_q == '0) ? Max : q_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o       = q_q;
  assign is_zero_o = (q_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit down-counter with per-digit moduli: borrow chain, zero/tc flags,
// saturate-or-wrap at zero and a registered done pulse.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int unsigned                NDIG     = TIMER_NDIG,
  parameter int unsigned                DIG_W    = TIMER_DIG_W,
  parameter logic [NDIG*DIG_W-1:0]      MODS     = TIMER_MODS_MMSS,
  parameter bit                         SATURATE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [NDIG*DIG_W-1:0] data_i,
  input  logic                  en_i,
  output logic [NDIG*DIG_W-1:0] count_o,
  output logic                  zero_o,
  output logic                  tc_o,
  output logic                  done_o
);

  logic [NDIG-1:0] is_zero;
  logic [NDIG-1:0] lower_zero;
  logic [NDIG-1:0] bin;
  logic            all_zero;
  logic            one_left;
  logic            done_d, done_q;

  always_comb begin
    logic acc;
    acc        = 1'b1;
    lower_zero = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      lower_zero[i] = acc;
      acc           = acc & is_zero[i];
    end
    all_zero = acc;
  end

  // At all-zero every digit sees a borrow, so wrap mode falls out of the chain for
  // free; saturate mode just suppresses the borrows.
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      bin[i] = en_i & lower_zero[i] & ~(SATURATE & all_zero);
    end
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam int unsigned ModField = get_digit(64'(MODS), i, DIG_W);
    // A zero field encodes the full 2**DIG_W modulus, which does not fit in DIG_W bits
    localparam int unsigned Mod      = (ModField == 0) ? (32'd1 << DIG_W) : ModField;

    mod_n_digit #(
      .MOD (Mod),
      .W   (DIG_W)
    ) u_digit (
      .clk_i     (clk_i),
      .clear_i   (clear_i),
      .load_i    (load_i),
      .d_i       (data_i[i*DIG_W +: DIG_W]),
      .bin_i     (bin[i]),
      .q_o       (count_o[i*DIG_W +: DIG_W]),
      .is_zero_o (is_zero[i])
    );
  end

  assign one_left = (count_o[DIG_W-1:0] == DIG_W'(1)) && ((count_o >> DIG_W) == '0);

  always_comb begin
    done_d = en_i & ~load_i & one_left;
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign zero_o = all_zero;
  assign tc_o   = en_i & all_zero;
  assign done_o = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: one saturating and one wrapping instance share
// the stimulus; expectations are queued per cycle and checked by an independent monitor.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        clear, load, en;
  logic [15:0] data;
  logic [15:0] cnt_s, cnt_w;
  logic        zero_s, zero_w, tc_s, tc_w, done_s, done_w;

  always #5 clk = ~clk;

  bcd_down_timer #(
    .NDIG     (4),
    .DIG_W    (4),
    .MODS     ({4'd10, 4'd10, 4'd6, 4'd10}),
    .SATURATE (1'b1)
  ) dut_sat (
    .clk_i   (clk),
    .clear_i (clear),
    .load_i  (load),
    .data_i  (data),
    .en_i    (en),
    .count_o (cnt_s),
    .zero_o  (zero_s),
    .tc_o    (tc_s),
    .done_o  (done_s)
  );

  bcd_down_timer #(
    .NDIG     (4),
    .DIG_W    (4),
    .MODS     ({4'd10, 4'd10, 4'd6, 4'd10}),
    .SATURATE (1'b0)
  ) dut_wrap (
    .clk_i   (clk),
    .clear_i (clear),
    .load_i  (load),
    .data_i  (data),
    .en_i    (en),
    .count_o (cnt_w),
    .zero_o  (zero_w),
    .tc_o    (tc_w),
    .done_o  (done_w)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [15:0] count;
    logic        zero;
    logic        tc;
    logic        done;
    bit          chk_tc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] m_cnt  [2];
  bit          m_done [2];

  localparam int ModV [4] = '{10, 6, 10, 10};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] gc;
    logic        gz, gt, gd;
    bit          ok;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      gc = (e.dut == 0) ? cnt_s  : cnt_w;
      gz = (e.dut == 0) ? zero_s : zero_w;
      gt = (e.dut == 0) ? tc_s   : tc_w;
      gd = (e.dut == 0) ? done_s : done_w;
      ok = (e.cyc == cyc) && (gc === e.count) && (gz === e.zero) && (gd === e.done) &&
           (!e.chk_tc || gt === e.tc);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc%0d: got count=%h zero=%b tc=%b done=%b, want count=%h zero=%b tc=%b done=%b",
                 e.name, e.dut, cyc, gc, gz, gt, gd, e.count, e.zero, e.tc, e.done);
      end
    end
  end

  function automatic logic [15:0] clamp(input logic [15:0] d);
    logic [15:0] r;
    int          dg;
    for (int i = 0; i < 4; i++) begin
      dg = int'(d[i*4 +: 4]);
      if (dg > ModV[i] - 1) dg = ModV[i] - 1;
      r[i*4 +: 4] = 4'(dg);
    end
    return r;
  endfunction

  // Count as total seconds: ss units, ss tens, mm units, mm tens
  function automatic int to_int(input logic [15:0] v);
    return int'(v[3:0]) + 10 * int'(v[7:4]) + 60 * int'(v[11:8]) + 600 * int'(v[15:12]);
  endfunction

  function automatic logic [15:0] from_int(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10); v = v / 10;
    r[7:4]   = 4'(v % 6);  v = v / 6;
    r[11:8]  = 4'(v % 10); v = v / 10;
    r[15:12] = 4'(v % 10);
    return r;
  endfunction

  task automatic expect_now(input string name, input int k, input logic [15:0] c,
                            input logic d);
    exp_t e;
    e = '{cyc: cyc, dut: k, count: c, zero: (c == 16'h0), tc: 1'b0, done: d, chk_tc: 1'b0,
          name: name};
    sb.push_back(e);
  endtask

  // Apply inputs for one edge; check the current cycle against the model, then advance it.
  task automatic drive(input bit c, input bit l, input logic [15:0] d, input bit e);
    exp_t        x;
    logic [15:0] n;
    bit          nd;
    clear = c; load = l; data = d; en = e;
    for (int k = 0; k < 2; k++) begin
      x = '{cyc: cyc, dut: k, count: m_cnt[k], zero: (m_cnt[k] == 16'h0),
            tc: e && (m_cnt[k] == 16'h0), done: m_done[k], chk_tc: 1'b1, name: "track"};
      sb.push_back(x);
      nd = 1'b0;
      if (c) begin
        n = 16'h0;
      end else if (l) begin
        n = clamp(d);
      end else if (e) begin
        if (m_cnt[k] != 16'h0) begin
          n  = from_int(to_int(m_cnt[k]) - 1);
          nd = (n == 16'h0);
        end else begin
          n = (k == 0) ? 16'h0000 : 16'h9959;
        end
      end else begin
        n = m_cnt[k];
      end
      m_cnt[k]  = n;
      m_done[k] = nd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; load = 1'b0; data = 16'h0; en = 1'b0;
    @(posedge clk);
    #1;
    m_cnt[0] = 16'h0; m_cnt[1] = 16'h0; m_done[0] = 1'b0; m_done[1] = 1'b0;

    // 1: clear with en high
    drive(1, 0, 16'h0, 1);
    expect_now("t1_reset_sat", 0, 16'h0000, 1'b0);
    expect_now("t1_reset_wrap", 1, 16'h0000, 1'b0);

    // 2: load 1:00, count down to zero, done for one cycle
    drive(0, 1, 16'h0100, 0);
    drive(0, 0, 16'h0, 1);
    expect_now("t2_first_dec", 0, 16'h0059, 1'b0);
    for (int i = 0; i < 59; i++) drive(0, 0, 16'h0, 1);
    expect_now("t2_zero_done", 0, 16'h0000, 1'b1);
    expect_now("t2_zero_done_w", 1, 16'h0000, 1'b1);
    drive(0, 0, 16'h0, 0);
    expect_now("t2_done_one_cycle", 0, 16'h0000, 1'b0);

    // 3: enabled at zero
    drive(0, 0, 16'h0, 1);
    expect_now("t3_sat_hold", 0, 16'h0000, 1'b0);
    expect_now("t3_wrap_full", 1, 16'h9959, 1'b0);
    drive(0, 0, 16'h0, 1);
    drive(0, 0, 16'h0, 1);
    expect_now("t3_sat_hold3", 0, 16'h0000, 1'b0);
    expect_now("t3_wrap_3", 1, 16'h9957, 1'b0);

    // 4: clamping load, and loading zero never pulses done
    drive(0, 1, 16'h0A7C, 0);
    expect_now("t4_clamp", 0, 16'h0959, 1'b0);
    drive(0, 1, 16'h0000, 1);
    expect_now("t4_load_zero", 0, 16'h0000, 1'b0);
    expect_now("t4_load_zero_w", 1, 16'h0000, 1'b0);

    // Borrow through every digit
    drive(0, 1, 16'h1000, 0);
    drive(0, 0, 16'h0, 1);
    expect_now("borrow_chain", 0, 16'h0959, 1'b0);

    // 5: load beats en
    drive(0, 1, 16'h0030, 0);
    drive(0, 1, 16'h0012, 1);
    expect_now("t5_load_wins", 0, 16'h0012, 1'b0);
    drive(0, 0, 16'h0, 1);
    expect_now("t5_next_dec", 0, 16'h0011, 1'b0);

    // 6: clear beats en at count 1
    drive(0, 1, 16'h0001, 0);
    drive(1, 0, 16'h0, 1);
    expect_now("t6_clear_wins", 0, 16'h0000, 1'b0);
    expect_now("t6_clear_wins_w", 1, 16'h0000, 1'b0);
    drive(0, 1, 16'h0001, 0);
    drive(0, 0, 16'h0, 1);
    expect_now("t6_one_to_zero", 0, 16'h0000, 1'b1);
    drive(0, 0, 16'h0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests += sb.size();
      n_fail  += sb.size();
      $display("FAIL drain: got %0d unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
